// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg -- shared definitions for the PC generator.
//   Exception cause encodings, the controller state encoding, the default
//   reset/vector constants and a small helper that classifies cause codes.
package pc_gen_pkg;

  localparam logic [4:0] EXC_CAUSE_INT  = 5'd0;
  localparam logic [4:0] EXC_CAUSE_ADEL = 5'd4;
  localparam logic [4:0] EXC_CAUSE_ADES = 5'd5;
  localparam logic [4:0] EXC_CAUSE_SYS  = 5'd8;
  localparam logic [4:0] EXC_CAUSE_BP   = 5'd9;
  localparam logic [4:0] EXC_CAUSE_RI   = 5'd10;
  localparam logic [4:0] EXC_CAUSE_OV   = 5'd12;
  localparam logic [4:0] EXC_CAUSE_TRAP = 5'd13;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FATAL = 2'd2
  } pc_state_e;

  localparam logic [31:0] DEF_RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] DEF_INT_VECTOR = 32'h0000_0020;
  localparam logic [31:0] DEF_EXC_VECTOR = 32'h0000_0040;

  // Causes that share the general exception vector.
  function automatic logic is_general_cause(input logic [4:0] cause);
    return (cause == EXC_CAUSE_ADEL) || (cause == EXC_CAUSE_ADES) ||
           (cause == EXC_CAUSE_SYS)  || (cause == EXC_CAUSE_BP)   ||
           (cause == EXC_CAUSE_RI)   || (cause == EXC_CAUSE_OV)   ||
           (cause == EXC_CAUSE_TRAP);
  endfunction

endpackage

// File: rtl/pc_gen_if.sv
// pc_gen_if -- fetch request and redirect bundle of the PC generator.
//   i_fetch_ready          : fetch accepts o_fetch_pc this cycle
//   i_br_valid/i_br_target : ID-stage branch/jump redirect
//   i_eret_valid/i_eret_epc: MEM-stage ERET and its EPC
//   i_exc_valid/i_exc_cause: exception being answered and its cause
//   i_ebase_we/i_ebase_wdata: EBASE write (only with PC_GEN_EBASE_EN)
//   o_fetch_pc/o_fetch_valid/o_fetch_kill: fetch request and cancel
//   o_misalign / o_fatal   : misaligned-ERET pulse, sticky unknown-cause flag
// Modports: master = pipeline side (drives redirects, consumes the request),
//           slave  = pc_gen.
// Macro: PC_GEN_EBASE_EN adds the EBASE write signals.
interface pc_gen_if #(
  parameter int ADDR_W = 32
);
  logic              i_fetch_ready;
  logic              i_br_valid;
  logic [ADDR_W-1:0] i_br_target;
  logic              i_eret_valid;
  logic [ADDR_W-1:0] i_eret_epc;
  logic              i_exc_valid;
  logic [4:0]        i_exc_cause;
`ifdef PC_GEN_EBASE_EN
  logic              i_ebase_we;
  logic [ADDR_W-1:0] i_ebase_wdata;
`endif
  logic [ADDR_W-1:0] o_fetch_pc;
  logic              o_fetch_valid;
  logic              o_fetch_kill;
  logic              o_misalign;
  logic              o_fatal;

  modport master (
`ifdef PC_GEN_EBASE_EN
    output i_ebase_we, i_ebase_wdata,
`endif
    output i_fetch_ready, i_br_valid, i_br_target, i_eret_valid, i_eret_epc,
           i_exc_valid, i_exc_cause,
    input  o_fetch_pc, o_fetch_valid, o_fetch_kill, o_misalign, o_fatal
  );

  modport slave (
`ifdef PC_GEN_EBASE_EN
    input  i_ebase_we, i_ebase_wdata,
`endif
    input  i_fetch_ready, i_br_valid, i_br_target, i_eret_valid, i_eret_epc,
           i_exc_valid, i_exc_cause,
    output o_fetch_pc, o_fetch_valid, o_fetch_kill, o_misalign, o_fatal
  );
endinterface

// File: rtl/pc_gen_vector.sv
// pc_gen_vector -- combinational exception cause to target lookup.
//   cause  : exception cause code
//   base   : vector base (EBASE, or zero when EBASE is not built)
//   target : base + INT_VECTOR / EXC_VECTOR; base when the cause is unknown
//   known  : the cause has a vector
module pc_gen_vector
  import pc_gen_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] INT_VECTOR = ADDR_W'(DEF_INT_VECTOR),
  parameter logic [ADDR_W-1:0] EXC_VECTOR = ADDR_W'(DEF_EXC_VECTOR)
) (
  input  logic [4:0]        cause,
  input  logic [ADDR_W-1:0] base,
  output logic [ADDR_W-1:0] target,
  output logic              known
);

  always_comb begin
    target = base;
    known  = 1'b0;
    if (cause == EXC_CAUSE_INT) begin
      target = base + INT_VECTOR;
      known  = 1'b1;
    end else if (is_general_cause(cause)) begin
      target = base + EXC_VECTOR;
      known  = 1'b1;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// pc_gen -- program counter generator with BOOT/RUN/FATAL control.
//   i_clk   : clock
//   i_reset : synchronous active-high reset
//   bus     : pc_gen_if.slave (fetch request, redirects, status flags)
// Redirect priority is exception > ERET > branch. A taken redirect loads the
// PC at the next edge regardless of fetch ready and kills the current fetch.
// An exception with an unknown cause freezes the block in FATAL until reset.
// Macro: PC_GEN_EBASE_EN builds a writable EBASE register; vectors then
// become offsets from it.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(DEF_RESET_PC),
  parameter logic [ADDR_W-1:0] INT_VECTOR = ADDR_W'(DEF_INT_VECTOR),
  parameter logic [ADDR_W-1:0] EXC_VECTOR = ADDR_W'(DEF_EXC_VECTOR),
  parameter int                STEP       = 4
) (
  input  logic    i_clk,
  input  logic    i_reset,
  pc_gen_if.slave bus
);

  pc_state_e         state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              misalign_q, misalign_d;
  logic              fatal_q, fatal_d;
  logic              fetch_valid;
  logic              fetch_kill;
  logic [ADDR_W-1:0] vec_base;
  logic [ADDR_W-1:0] exc_target;
  logic              exc_known;

`ifdef PC_GEN_EBASE_EN
  logic [ADDR_W-1:0] ebase_q;
  // Low 12 bits are forced to zero; keep them visible as intentionally unused.
  logic              ebase_low_unused;
  assign ebase_low_unused = ^bus.i_ebase_wdata[11:0];

  // Exceptions read ebase_q, so a same-cycle write only affects later ones.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ebase_q <= '0;
    end else if (bus.i_ebase_we) begin
      ebase_q <= {bus.i_ebase_wdata[ADDR_W-1:12], 12'h000};
    end
  end
  assign vec_base = ebase_q;
`else
  assign vec_base = '0;
`endif

  pc_gen_vector #(
    .ADDR_W     (ADDR_W),
    .INT_VECTOR (INT_VECTOR),
    .EXC_VECTOR (EXC_VECTOR)
  ) u_vector (
    .cause  (bus.i_exc_cause),
    .base   (vec_base),
    .target (exc_target),
    .known  (exc_known)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    misalign_d  = 1'b0;
    fatal_d     = fatal_q;
    fetch_valid = 1'b0;
    fetch_kill  = 1'b0;

    case (state_q)
      BOOT:    state_d     = RUN;
      RUN:     fetch_valid = 1'b1;
      default: state_d     = FATAL;
    endcase

    // FATAL ignores every redirect and never advances.
    if (state_q != FATAL) begin
      if (bus.i_exc_valid) begin
        if (exc_known) begin
          pc_d = exc_target;
        end else begin
          fatal_d = 1'b1;
          state_d = FATAL;
        end
      end else if (bus.i_eret_valid) begin
        pc_d       = {bus.i_eret_epc[ADDR_W-1:2], 2'b00};
        misalign_d = |bus.i_eret_epc[1:0];
      end else if (bus.i_br_valid) begin
        pc_d = bus.i_br_target;
      end else if (fetch_valid && bus.i_fetch_ready) begin
        pc_d = pc_q + ADDR_W'(STEP);
      end
      fetch_kill = (state_q == RUN) &&
                   (bus.i_exc_valid || bus.i_eret_valid || bus.i_br_valid);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      misalign_q <= 1'b0;
      fatal_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
      fatal_q    <= fatal_d;
    end
  end

  assign bus.o_fetch_pc    = pc_q;
  assign bus.o_fetch_valid = fetch_valid;
  assign bus.o_fetch_kill  = fetch_kill;
  assign bus.o_misalign    = misalign_q;
  assign bus.o_fatal       = fatal_q;

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen -- self-checking bench for pc_gen.
// Each vector drives one cycle of inputs; o_fetch_valid / o_fetch_kill are
// checked before the edge, and the post-edge PC / misalign / fatal values are
// queued when driven and popped after the edge.
// With PC_GEN_EBASE_EN defined, an extra EBASE sequence runs.
module tb_pc_gen;
  import pc_gen_pkg::*;

  typedef struct {
    logic        rdy;
    logic        br_v;
    logic [31:0] br_t;
    logic        er_v;
    logic [31:0] epc;
    logic        ex_v;
    logic [4:0]  cause;
    logic        ew;
    logic [31:0] ewd;
    logic        exp_valid;
    logic        exp_kill;
    logic        chk_kill;
    logic [31:0] exp_pc;
    logic        exp_mis;
    logic        exp_fatal;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic        mis;
    logic        fatal;
  } exp_t;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;
  exp_t sb[$];
  vec_t tbl[$];

  pc_gen_if #(.ADDR_W(32)) bus ();

  pc_gen dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rdy, input logic br_v, input logic [31:0] br_t,
                              input logic er_v, input logic [31:0] epc,
                              input logic ex_v, input logic [4:0] cause,
                              input logic ev, input logic ek, input logic ck,
                              input logic [31:0] pc, input logic mis, input logic fat);
    vec_t v;
    v.rdy = rdy; v.br_v = br_v; v.br_t = br_t; v.er_v = er_v; v.epc = epc;
    v.ex_v = ex_v; v.cause = cause; v.ew = 1'b0; v.ewd = '0;
    v.exp_valid = ev; v.exp_kill = ek; v.chk_kill = ck;
    v.exp_pc = pc; v.exp_mis = mis; v.exp_fatal = fat;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    bus.i_fetch_ready = v.rdy;
    bus.i_br_valid    = v.br_v;
    bus.i_br_target   = v.br_t;
    bus.i_eret_valid  = v.er_v;
    bus.i_eret_epc    = v.epc;
    bus.i_exc_valid   = v.ex_v;
    bus.i_exc_cause   = v.cause;
`ifdef PC_GEN_EBASE_EN
    bus.i_ebase_we    = v.ew;
    bus.i_ebase_wdata = v.ewd;
`endif
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s sb: got empty queue expected entry", tag);
    end else begin
      e = sb.pop_front();
      check({tag, " pc"}, bus.o_fetch_pc, e.pc);
      check({tag, " misalign"}, bus.o_misalign, e.mis);
      check({tag, " fatal"}, bus.o_fatal, e.fatal);
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    exp_t e;
    drive(v);
    e.pc = v.exp_pc; e.mis = v.exp_mis; e.fatal = v.exp_fatal;
    sb.push_back(e);
    @(negedge clk);
    check({tag, " valid"}, bus.o_fetch_valid, v.exp_valid);
    if (v.chk_kill) check({tag, " kill"}, bus.o_fetch_kill, v.exp_kill);
    @(posedge clk);
    #1;
    pop_check(tag);
  endtask

  // Reset with all redirects (and an EBASE write) active to show reset wins.
  task automatic do_reset(input string tag);
    vec_t j;
    exp_t e;
    j = mk(1, 1, 32'h0000_0700, 1, 32'h0000_3003, 1, EXC_CAUSE_OV, 0, 0, 0, 0, 0, 0);
    j.ew = 1'b1; j.ewd = 32'hFFFF_F000;
    drive(j);
    rst = 1'b1;
    e.pc = 32'h0; e.mis = 1'b0; e.fatal = 1'b0;
    sb.push_back(e);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    pop_check(tag);
    check({tag, " valid"}, bus.o_fetch_valid, 1'b0);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    //           rdy br  br_t          er  epc           ex  cause           v  k  ck pc            mis fat
    tbl.push_back(mk(1, 0, 0,            0, 0,            0, 0,              0, 0, 1, 32'h0000_0000, 0, 0));
    tbl.push_back(mk(1, 0, 0,            0, 0,            0, 0,              1, 0, 1, 32'h0000_0004, 0, 0));
    tbl.push_back(mk(1, 0, 0,            0, 0,            0, 0,              1, 0, 1, 32'h0000_0008, 0, 0));
    tbl.push_back(mk(1, 0, 0,            0, 0,            0, 0,              1, 0, 1, 32'h0000_000C, 0, 0));
    tbl.push_back(mk(1, 0, 0,            0, 0,            0, 0,              1, 0, 1, 32'h0000_0010, 0, 0));
    tbl.push_back(mk(0, 0, 0,            0, 0,            0, 0,              1, 0, 1, 32'h0000_0010, 0, 0));
    tbl.push_back(mk(0, 0, 0,            0, 0,            0, 0,              1, 0, 1, 32'h0000_0010, 0, 0));
    tbl.push_back(mk(0, 0, 0,            0, 0,            0, 0,              1, 0, 1, 32'h0000_0010, 0, 0));
    tbl.push_back(mk(0, 1, 32'h100,      0, 0,            0, 0,              1, 1, 1, 32'h0000_0100, 0, 0));
    tbl.push_back(mk(1, 1, 32'h300,      1, 32'h2000,     1, EXC_CAUSE_OV,   1, 1, 1, 32'h0000_0040, 0, 0));
    tbl.push_back(mk(0, 1, 32'h300,      1, 32'h2000,     1, EXC_CAUSE_INT,  1, 1, 1, 32'h0000_0020, 0, 0));
    tbl.push_back(mk(1, 1, 32'h500,      1, 32'h1000,     0, 0,              1, 1, 1, 32'h0000_1000, 0, 0));
    tbl.push_back(mk(1, 0, 0,            1, 32'h1002,     0, 0,              1, 1, 1, 32'h0000_1000, 1, 0));
    tbl.push_back(mk(1, 0, 0,            0, 0,            0, 0,              1, 0, 1, 32'h0000_1004, 0, 0));
    tbl.push_back(mk(0, 1, 32'hFFFFFFF8, 0, 0,            0, 0,              1, 1, 1, 32'hFFFF_FFF8, 0, 0));
    tbl.push_back(mk(1, 0, 0,            0, 0,            0, 0,              1, 0, 1, 32'hFFFF_FFFC, 0, 0));
    tbl.push_back(mk(1, 0, 0,            0, 0,            0, 0,              1, 0, 1, 32'h0000_0000, 0, 0));
    tbl.push_back(mk(1, 0, 0,            0, 0,            1, EXC_CAUSE_ADEL, 1, 1, 1, 32'h0000_0040, 0, 0));
    tbl.push_back(mk(1, 0, 0,            0, 0,            1, EXC_CAUSE_BP,   1, 1, 1, 32'h0000_0040, 0, 0));
    tbl.push_back(mk(1, 0, 0,            0, 0,            1, 5'h1F,          1, 0, 0, 32'h0000_0040, 0, 1));
    tbl.push_back(mk(1, 1, 32'h200,      0, 0,            0, 0,              0, 0, 1, 32'h0000_0040, 0, 1));
    tbl.push_back(mk(1, 0, 0,            0, 0,            1, EXC_CAUSE_INT,  0, 0, 1, 32'h0000_0040, 0, 1));
    tbl.push_back(mk(1, 0, 0,            1, 32'h3000,     0, 0,              0, 0, 1, 32'h0000_0040, 0, 1));

    @(posedge clk);
    #1;
    do_reset("reset0");
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Reset leaves FATAL; a redirect in BOOT is taken and RUN follows.
    do_reset("reset_fatal");
    apply(mk(1, 1, 32'h400, 0, 0, 0, 0, 0, 0, 1, 32'h0000_0400, 0, 0), "boot_br");
    apply(mk(1, 0, 0,       0, 0, 0, 0, 1, 0, 1, 32'h0000_0404, 0, 0), "boot_run");
    apply(mk(1, 0, 0, 1, 32'h2003, 0, 0, 1, 1, 1, 32'h0000_2000, 1, 0), "eret_mis");
    do_reset("reset_mis");

`ifdef PC_GEN_EBASE_EN
    begin
      vec_t v;
      v = mk(1, 0, 0, 0, 0, 1, EXC_CAUSE_SYS, 0, 0, 1, 32'h0000_0040, 0, 0);
      v.ew = 1'b1; v.ewd = 32'h8000_1234;
      apply(v, "ebase_same");
      apply(mk(1, 0, 0, 0, 0, 1, EXC_CAUSE_SYS, 1, 1, 1, 32'h8000_1040, 0, 0), "ebase_sys");
      apply(mk(1, 0, 0, 0, 0, 1, EXC_CAUSE_INT, 1, 1, 1, 32'h8000_1020, 0, 0), "ebase_int");
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: PC and target width.
REQ-002 SHALL have parameter RESET_PC, default 32'h00000000: PC value loaded by reset.
REQ-003 SHALL have parameter INT_VECTOR, default 32'h00000020: interrupt vector, or the offset from EBASE when EBASE is built.
REQ-004 SHALL have parameter EXC_VECTOR, default 32'h00000040: general exception vector, or the offset from EBASE when EBASE is built.
REQ-005 SHALL have parameter STEP, default 4: sequential increment in bytes.
REQ-006 SHALL have port i_clk, input, 1 bit: the single clock.
REQ-007 SHALL have port i_reset, input, 1 bit: reset, synchronous and active-high.
REQ-008 SHALL have port i_fetch_ready, input, 1 bit: fetch stage accepts o_fetch_pc this cycle.
REQ-009 SHALL have port i_br_valid / i_br_target, input, 1 / ADDR_W bits: ID-stage branch/jump redirect.
REQ-010 SHALL have port i_eret_valid / i_eret_epc, input, 1 / ADDR_W bits: MEM-stage ERET and EPC value.
REQ-011 SHALL have port i_exc_valid / i_exc_cause, input, 1 / 5 bits: exception being answered, and its cause code.
REQ-012 SHALL have port i_ebase_we / i_ebase_wdata, input, 1 / ADDR_W bits: EBASE write; present only with PC_GEN_EBASE_EN.
REQ-013 SHALL have port o_fetch_pc, output, ADDR_W bits: current PC presented to fetch.
REQ-014 SHALL have port o_fetch_valid, output, 1 bit: o_fetch_pc is a valid request.
REQ-015 SHALL have port o_fetch_kill, output, 1 bit: combinational; a redirect this cycle cancels any handshake.
REQ-016 SHALL have port o_misalign, output, 1 bit: one-cycle pulse; the ERET target was misaligned.
REQ-017 SHALL have port o_fatal, output, 1 bit: sticky; an unknown exception cause was seen.

Function
REQ-018 SHALL hold the PC in register pc_q, with o_fetch_pc = pc_q.
REQ-019 SHALL implement states BOOT, RUN and FATAL.
REQ-020 In BOOT, o_fetch_valid SHALL be 0 and the block SHALL go to RUN on the next cycle.
REQ-021 In RUN, o_fetch_valid SHALL be 1.
REQ-022 In FATAL, o_fetch_valid SHALL be 0 and pc_q SHALL be frozen.
REQ-023 SHALL prioritise redirects exc > eret > br; only the highest-priority valid redirect is taken.
REQ-024 A redirect taken in RUN SHALL load pc_q with its target at the next edge, regardless of i_fetch_ready, and SHALL assert o_fetch_kill that cycle.
REQ-025 Exception target SHALL be INT_VECTOR for EXC_CAUSE_INT.
REQ-026 Exception target SHALL be EXC_VECTOR for EXC_CAUSE_ADEL, ADES, SYS, BP, RI, OV and TRAP.
REQ-027 Any other exception cause SHALL leave pc_q unchanged, set o_fatal and move the block to FATAL.
REQ-028 ERET target SHALL be {i_eret_epc[ADDR_W-1:2], 2'b00}.
REQ-029 If i_eret_epc[1:0] != 0, the ERET SHALL still be taken and o_misalign SHALL pulse for exactly one cycle, the cycle after.
REQ-030 With no redirect, pc_q SHALL advance by STEP only when o_fetch_valid && i_fetch_ready; otherwise pc_q holds.
REQ-031 Sequential advance SHALL wrap modulo 2^ADDR_W (0xFFFFFFFC + 4 -> 0x00000000) with no flag.
REQ-032 Redirects arriving in BOOT SHALL be taken: pc_q is loaded and the transition to RUN is unaffected.
REQ-033 Redirects in FATAL SHALL be ignored.

Reset
REQ-034 On i_reset=1 at a clock edge: pc_q=RESET_PC, state=BOOT, o_fatal=0, o_misalign=0, and EBASE=0 when built.
REQ-035 Reset SHALL override all redirects and any EBASE write in the same cycle.
REQ-036 Reset SHALL be the only exit from FATAL.

Configuration
REQ-037 With PC_GEN_EBASE_EN defined, register EBASE SHALL be built.
REQ-038 EBASE SHALL load {i_ebase_wdata[ADDR_W-1:12], 12'h000} when i_ebase_we=1.
REQ-039 With PC_GEN_EBASE_EN defined, vectors SHALL be EBASE+INT_VECTOR and EBASE+EXC_VECTOR.
REQ-040 An exception in the same cycle as an EBASE write SHALL use the old EBASE.
REQ-041 Without PC_GEN_EBASE_EN, the EBASE ports and register SHALL be absent and the vectors SHALL be INT_VECTOR and EXC_VECTOR as absolute addresses.

Structure
REQ-042 The shared package SHALL hold the EXC_CAUSE_* encodings, the BOOT/RUN/FATAL state encoding and the default vector constants.
REQ-043 The cause-to-target lookup SHALL be sub-module pc_gen_vector: combinational, inputs cause and base, outputs target and known-cause flag.

Verification
REQ-044 Reset release, i_fetch_ready=1 -> o_fetch_valid=0 for one cycle, then PCs 0x0, 0x4, 0x8 on consecutive cycles.
REQ-045 i_fetch_ready=0 for 3 cycles at PC 0x10 -> PC holds 0x10; i_br_valid=1 with target 0x100 during the stall -> o_fetch_kill=1 and next PC 0x100.
REQ-046 i_exc_valid=1 with cause OV, plus i_eret_valid=1 and i_br_valid=1 in the same cycle -> next PC 0x40; with cause INT -> next PC 0x20.
REQ-047 ERET with EPC 0x1002 -> next PC 0x1000 and o_misalign pulses one cycle; unknown cause 5'h1F -> o_fatal=1, o_fetch_valid=0 and PC frozen until reset.
REQ-048 With PC_GEN_EBASE_EN: write 0x80001234 then exception SYS -> PC 0x80001040; EBASE write and exception in the same cycle -> PC 0x00000040.
